// File: rtl/li_expander.sv
// li_expander: load-immediate expander.
// Turns a 32-bit constant plus a destination register into the shortest MIPS
// sequence that loads it: ADDIU, ORI, or LUI optionally followed by ORI.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   inValid/inReady        request handshake (accept on inValid && inReady)
//   inValue[31:0]          constant to load
//   inRt[4:0]              destination register
//   outValid/outReady      instruction handshake (transfer on both high)
//   outInstr[31:0]         encoded instruction word
//   outLast                final word of the current sequence
//
// Parameters:
//   SKIP_ZERO_ORI          1: omit the trailing ORI when value[15:0] == 0
//
// Optional build macro LI_EXPANDER_STATS_EN adds saturating counters:
//   totalCount[15:0]       accepted requests
//   twoWordCount[15:0]     accepted requests emitted as LUI+ORI
module li_expander #(
  parameter bit SKIP_ZERO_ORI = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inValid,
  output logic        inReady,
  input  logic [31:0] inValue,
  input  logic [4:0]  inRt,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] outInstr,
  output logic        outLast
`ifdef LI_EXPANDER_STATS_EN
  ,
  output logic [15:0] twoWordCount,
  output logic [15:0] totalCount
`endif
);

  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WORD1 = 2'd1,
    WORD2 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q,  last_d;
  logic [15:0] lo_q,    lo_d;
  logic [4:0]  rt_q,    rt_d;

  logic        accept;
  logic        xfer;
  logic [31:0] first_instr;
  logic        first_last;
  logic        first_two;

  // All outputs come from flops; inValue/inRt only feed next-state logic.
  assign outValid = (state_q != IDLE);
  assign outInstr = instr_q;
  assign outLast  = last_q;
  assign xfer     = outValid && outReady;
  assign inReady  = !reset && ((state_q == IDLE) || (xfer && last_q));
  assign accept   = inValid && inReady;

  // Classification of an incoming request, in priority order.
  always_comb begin
    first_instr = '0;
    first_last  = 1'b1;
    first_two   = 1'b0;
    if (inRt == 5'd0) begin
      first_instr = '0;
    end else if ((&inValue[31:15]) || !(|inValue[31:15])) begin
      first_instr = {OP_ADDIU, 5'd0, inRt, inValue[15:0]};
    end else if (inValue[31:16] == 16'h0000) begin
      first_instr = {OP_ORI, 5'd0, inRt, inValue[15:0]};
    end else begin
      first_instr = {OP_LUI, 5'd0, inRt, inValue[31:16]};
      if (SKIP_ZERO_ORI && (inValue[15:0] == 16'h0000)) begin
        first_last = 1'b1;
      end else begin
        first_last = 1'b0;
        first_two  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    last_d  = last_q;
    lo_d    = lo_q;
    rt_d    = rt_q;
    // A new accept always wins: it can only coincide with IDLE or with the
    // transfer of a last word, so it never clobbers a pending second word.
    if (accept) begin
      state_d = WORD1;
      instr_d = first_instr;
      last_d  = first_last;
      lo_d    = inValue[15:0];
      rt_d    = inRt;
    end else if (xfer) begin
      if ((state_q == WORD1) && !last_q) begin
        state_d = WORD2;
        instr_d = {OP_ORI, rt_q, rt_q, lo_q};
        last_d  = 1'b1;
      end else begin
        state_d = IDLE;
        instr_d = '0;
        last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      last_q  <= 1'b0;
      lo_q    <= '0;
      rt_q    <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      lo_q    <= lo_d;
      rt_q    <= rt_d;
    end
  end

`ifdef LI_EXPANDER_STATS_EN
  logic [15:0] total_q, total_d;
  logic [15:0] two_q,   two_d;

  always_comb begin
    total_d = total_q;
    two_d   = two_q;
    if (accept && (total_q != 16'hFFFF)) begin
      total_d = total_q + 16'd1;
    end
    if (accept && first_two && (two_q != 16'hFFFF)) begin
      two_d = two_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_q <= '0;
      two_q   <= '0;
    end else begin
      total_q <= total_d;
      two_q   <= two_d;
    end
  end

  assign totalCount   = total_q;
  assign twoWordCount = two_q;
`endif

endmodule

// File: tb/tb_li_expander.sv
// Testbench for li_expander: directed requests with hand-computed expected
// instruction words pushed into a scoreboard; a monitor pops and compares on
// every output transfer and also checks that held words stay stable.
module tb_li_expander;

  typedef struct packed {
    logic [31:0] instr;
    logic        last;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [31:0] inValue;
  logic [4:0]  inRt;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInstr;
  logic        outLast;

  logic        inValid0;
  logic        inReady0;
  logic [31:0] inValue0;
  logic [4:0]  inRt0;
  logic        outValid0;
  logic        outReady0;
  logic [31:0] outInstr0;
  logic        outLast0;

`ifdef LI_EXPANDER_STATS_EN
  logic [15:0] twoWordCount, totalCount;
  logic [15:0] twoWordCount0, totalCount0;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        sb[$];
  logic        b2b_phase = 1'b0;

  li_expander #(.SKIP_ZERO_ORI(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .inValid(inValid), .inReady(inReady), .inValue(inValue), .inRt(inRt),
    .outValid(outValid), .outReady(outReady), .outInstr(outInstr), .outLast(outLast)
`ifdef LI_EXPANDER_STATS_EN
    , .twoWordCount(twoWordCount), .totalCount(totalCount)
`endif
  );

  li_expander #(.SKIP_ZERO_ORI(1'b0)) u_dut0 (
    .clk(clk), .reset(reset),
    .inValid(inValid0), .inReady(inReady0), .inValue(inValue0), .inRt(inRt0),
    .outValid(outValid0), .outReady(outReady0), .outInstr(outInstr0), .outLast(outLast0)
`ifdef LI_EXPANDER_STATS_EN
    , .twoWordCount(twoWordCount0), .totalCount(totalCount0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: compare every transfer against the scoreboard, and require
  // outInstr/outLast to stay put while the consumer stalls.
  logic        held_v = 1'b0;
  logic [31:0] held_instr;
  logic        held_last;
  exp_t        e;

  always @(negedge clk) begin
    if (b2b_phase) chk("b2b_inReady", {31'd0, inReady}, 32'd1);
    if (outValid) begin
      if (held_v) begin
        chk("hold_instr", outInstr, held_instr);
        chk("hold_last", {31'd0, outLast}, {31'd0, held_last});
      end
      if (outReady) begin
        held_v = 1'b0;
        if (sb.size() == 0) begin
          chk("unexpected_word", outInstr, 32'hDEADDEAD);
        end else begin
          e = sb.pop_front();
          chk("word_instr", outInstr, e.instr);
          chk("word_last", {31'd0, outLast}, {31'd0, e.last});
        end
      end else begin
        held_v     = 1'b1;
        held_instr = outInstr;
        held_last  = outLast;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  // Issue one request and push its expected words; returns #1 after the
  // accepting edge, with inValid dropped.
  task automatic send(input logic [31:0] v, input logic [4:0] rt,
                      input logic [31:0] w1, input logic l1,
                      input logic has2, input logic [31:0] w2);
    logic acc;
    int unsigned n;
    inValid = 1'b1;
    inValue = v;
    inRt    = rt;
    n = 0;
    do begin
      @(negedge clk);
      acc = inReady;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    inValid = 1'b0;
    if (!acc) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      sb.push_back('{instr: w1, last: l1});
      if (has2) sb.push_back('{instr: w2, last: 1'b1});
      chk("latency_outValid", {31'd0, outValid}, 32'd1);
    end
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", sb.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    inValid = 1'b0; inValue = '0; inRt = '0; outReady = 1'b0;
    inValid0 = 1'b0; inValue0 = '0; inRt0 = '0; outReady0 = 1'b1;
    #2;
    chk("rst_outValid", {31'd0, outValid}, 32'd0);
    chk("rst_outInstr", outInstr, 32'd0);
    chk("rst_outLast", {31'd0, outLast}, 32'd0);
    chk("rst_inReady", {31'd0, inReady}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    outReady = 1'b1;
    send(32'h00000005, 5'd8,  32'h24080005, 1'b1, 1'b0, 32'h0);
    drain();
    send(32'hFFFF8000, 5'd9,  32'h24098000, 1'b1, 1'b0, 32'h0);
    send(32'h0000ABCD, 5'd10, 32'h340AABCD, 1'b1, 1'b0, 32'h0);
    drain();

    // Two-word sequence with three stall cycles on each word.
    outReady = 1'b0;
    send(32'h12345678, 5'd11, 32'h3C0B1234, 1'b0, 1'b1, 32'h356B5678);
    repeat (3) begin @(posedge clk); #1; end
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    outReady = 1'b1;
    drain();

    send(32'h00010000, 5'd2, 32'h3C020001, 1'b1, 1'b0, 32'h0);
    send(32'h12345678, 5'd0, 32'h00000000, 1'b1, 1'b0, 32'h0);
    drain();

    // Back-to-back single words: inReady must stay high throughout.
    send(32'h00000001, 5'd3, 32'h24030001, 1'b1, 1'b0, 32'h0);
    b2b_phase = 1'b1;
    send(32'hFFFFFFFF, 5'd4, 32'h2404FFFF, 1'b1, 1'b0, 32'h0);
    send(32'h00008000, 5'd5, 32'h34058000, 1'b1, 1'b0, 32'h0);
    send(32'h00007FFF, 5'd6, 32'h24067FFF, 1'b1, 1'b0, 32'h0);
    send(32'hABCD0000, 5'd0, 32'h00000000, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    b2b_phase = 1'b0;
    drain();

    // Always-emit-ORI variant of the zero-low-half case.
    inValid0 = 1'b1; inValue0 = 32'h00010000; inRt0 = 5'd2;
    @(posedge clk); #1;
    inValid0 = 1'b0;
    chk("noskip_w1_valid", {31'd0, outValid0}, 32'd1);
    chk("noskip_w1_instr", outInstr0, 32'h3C020001);
    chk("noskip_w1_last", {31'd0, outLast0}, 32'd0);
    @(posedge clk); #1;
    chk("noskip_w2_valid", {31'd0, outValid0}, 32'd1);
    chk("noskip_w2_instr", outInstr0, 32'h34420000);
    chk("noskip_w2_last", {31'd0, outLast0}, 32'd1);
    @(posedge clk); #1;
    chk("noskip_idle", {31'd0, outValid0}, 32'd0);

    // Reset during the second word abandons the sequence at once.
    outReady = 1'b0;
    send(32'h12345678, 5'd11, 32'h3C0B1234, 1'b0, 1'b1, 32'h356B5678);
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    chk("w2_before_reset", outInstr, 32'h356B5678);
    reset = 1'b1;
    #1;
    sb.delete();
    chk("midrst_outValid", {31'd0, outValid}, 32'd0);
    chk("midrst_outInstr", outInstr, 32'd0);
    chk("midrst_outLast", {31'd0, outLast}, 32'd0);
    chk("midrst_inReady", {31'd0, inReady}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", {31'd0, outValid}, 32'd0);
    outReady = 1'b1;
    send(32'h00000005, 5'd8, 32'h24080005, 1'b1, 1'b0, 32'h0);
    drain();
`ifdef LI_EXPANDER_STATS_EN
    chk("stats_total", {16'd0, totalCount}, 32'd1);
    chk("stats_two", {16'd0, twoWordCount}, 32'd0);
`endif
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
